drum_motor_driver: RTL and testbench
====================================

Name: drum_motor_driver

Overview:
- Downstream power stage for the wash controller's motor-enable output (M1, asserted during the wash phase).
- Converts the level request into an alternating forward/reverse drum drive: soft-start PWM ramp, fixed run time, dead-time pause, then direction reversal.
- Cuts drive immediately when the door-interlock input opens.
- Reports running/fault status and a reversal count for the seven-segment display path.

Parameters:
- TICK_DIV, 50000: clk cycles per time-base tick (1 ms at 50 MHz).
- RAMP_STEP, 8: duty increment applied per tick during soft-start.
- MAX_DUTY, 200: full-run duty (0-255 scale).
- RUN_TICKS, 3000: ticks held at MAX_DUTY per direction.
- PAUSE_TICKS, 500: dead-time ticks between directions; both direction outputs low.

Ports:
- clk  in  1  system clock; all logic on posedge.
- O  in  1  asynchronous active-low reset; clears all state.
- en  in  1  motor request (driven by M1); level-sensitive.
- door_closed  in  1  interlock; 1 = door shut. Synchronised internally with 2 flops.
- pwm  out  1  motor PWM gate.
- dir_fwd  out  1  forward bridge enable.
- dir_rev  out  1  reverse bridge enable.
- running  out  1  1 in RAMP or RUN.
- fault  out  1  1 in FAULT.
- reversals  out  8  completed direction reversals; saturates at 255.

Behaviour:
- Reset (O=0, async): state=IDLE, duty=0, dir=FWD, tick prescaler=0, pwm counter=0, timers=0, sync flops=0.
  - All outputs 0, including reversals.
- Time base: free-running prescaler 0..TICK_DIV-1. tick=1 for one clk when the prescaler wraps. First tick occurs TICK_DIV clocks after reset release.
- PWM: free-running 8-bit pwm_cnt, +1 every clk, wraps 255->0.
  - pwm = (pwm_cnt < duty) AND state in {RAMP, RUN}, registered (1-clk latency).
  - duty=0 means pwm is constantly 0.
- dir_fwd = (dir==FWD) AND state in {RAMP, RUN}. dir_rev is the same with REV.
  - Both are never 1 together.
  - Both are 0 in IDLE, PAUSE and FAULT.
- The door input used below is the synchronised door_closed (ds).
- States and transitions, evaluated on posedge clk in priority order:
  1. en=0 (any state) -> IDLE. duty=0, dir=FWD, timer=0. reversals holds its value.
  2. en=1 and ds=0 (any state) -> FAULT. duty=0 in the same cycle.
  3. IDLE: on en=1 and ds=1 -> RAMP. duty=0, reversals cleared to 0 on this entry.
  4. RAMP: on each tick, duty = min(duty+RAMP_STEP, MAX_DUTY).
     - When the updated duty equals MAX_DUTY -> RUN, timer=0.
  5. RUN: timer +1 per tick. When timer reaches RUN_TICKS-1 on a tick -> PAUSE.
     - On that transition: duty=0, timer=0.
  6. PAUSE: timer +1 per tick. When timer reaches PAUSE_TICKS-1 on a tick:
     - dir toggles, reversals +1 (saturating at 255), -> RAMP with duty=0.
  7. FAULT: holds duty=0 and outputs off. Leaves only via rule 1 (en=0).
     - Door re-closing alone does not restart the drum.
- Arithmetic widths:
  - duty addition is 9 bits, clamped to MAX_DUTY.
  - timer is 16 bits; RUN_TICKS and PAUSE_TICKS must be ≤ 65535.
  - reversals never wraps.
- Reversal counting: reversals increments only on completed PAUSE -> RAMP transitions. An aborted cycle (en drop or fault) does not count.
- Mid-operation en drop: the drive stops within 1 clk. The next en=1 restarts in FWD from duty 0.
- Reset mid-operation: drive outputs go 0 immediately (asynchronous). No residual pwm pulse.
- pwm duty updates take effect at the current pwm_cnt compare; no period-boundary latching is required.

Test Plan:
- Bench parameters: TICK_DIV=4, RAMP_STEP=50, MAX_DUTY=200, RUN_TICKS=10, PAUSE_TICKS=3.
- Reset, en=0, door=1 -> all outputs 0 for 100 clk; assert O=0 mid-run -> pwm, dir_fwd, running drop to 0 in the same cycle.
- en=1, door=1 -> running=1, dir_fwd=1.
  - duty 50, 100, 150, 200 on successive ticks; RUN after 4 ticks.
  - pwm high for 200 of each 256 clk in RUN.
- Continue -> after 10 RUN ticks, PAUSE: dir_fwd=dir_rev=pwm=0 for 3 ticks.
  - Then dir_rev=1 and reversals=1; second PAUSE gives dir_fwd=1, reversals=2.
- Door opens during RUN (door_closed 1->0) -> fault=1 and pwm=0 within 3 clk.
  - Door re-closes -> stays FAULT.
  - en 0 -> IDLE, fault=0; en 1 -> ramp restarts FWD, reversals=0.
- en drops during PAUSE after 1 reversal -> IDLE with reversals held at 1, dir outputs 0.
  - en reasserted -> reversals cleared to 0, drive restarts forward.
- Force 256 reversals (RUN_TICKS=1, PAUSE_TICKS=1) -> reversals stops at 255, no wrap.

Source files
------------

// File: rtl/drum_motor_driver.sv
// ---------------------------------------------------------------------------
// drum_motor_driver
//
// Power-stage sequencer for the wash drum. It turns the level motor request
// (en, driven by M1) into an alternating forward/reverse drive. Each
// direction goes through a soft-start PWM ramp, a fixed run time and a
// dead-time pause, and then the direction reverses. Drive is cut as soon as
// the synchronised door interlock opens. The block then latches FAULT until
// en is dropped.
//
// Ports:
//   clk          system clock; all logic on posedge
//   O            asynchronous active-low reset; clears all state
//   en           motor request, level-sensitive
//   door_closed  door interlock (1 = shut), 2-flop synchronised internally
//   pwm          motor PWM gate, registered
//   dir_fwd      forward bridge enable
//   dir_rev      reverse bridge enable
//   running      1 while ramping or running
//   fault        1 while latched in FAULT
//   reversals    completed direction reversals, saturating at 255
//   state_dbg    current FSM state encoding, for observation only
//
// There is no handshake. en is a plain level, and the outputs are levels
// derived from the registered state.
// ---------------------------------------------------------------------------
module drum_motor_driver #(
    parameter int TICK_DIV    = 50000,
    parameter int RAMP_STEP   = 8,
    parameter int MAX_DUTY    = 200,
    parameter int RUN_TICKS   = 3000,
    parameter int PAUSE_TICKS = 500
) (
    input  logic       clk,
    input  logic       O,
    input  logic       en,
    input  logic       door_closed,
    output logic       pwm,
    output logic       dir_fwd,
    output logic       dir_rev,
    output logic       running,
    output logic       fault,
    output logic [7:0] reversals,
    output logic [2:0] state_dbg
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        FAULT = 3'd4
    } state_t;

    typedef enum logic {
        FWD = 1'b0,
        REV = 1'b1
    } dir_t;

    state_t        state, state_n;
    dir_t          dir, dir_n;
    logic [7:0]    duty, duty_n;
    logic [15:0]   timer, timer_n;
    logic [7:0]    rev_n;
    logic [PW-1:0] presc;
    logic [7:0]    pwm_cnt;
    logic          door_s1, ds;
    logic          tick;
    logic [8:0]    duty_sum;
    logic          drive_n;

    // Time base and PWM carrier are free-running and independent of the FSM.
    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge O) begin
        if (!O) begin
            presc   <= '0;
            pwm_cnt <= '0;
            door_s1 <= 1'b0;
            ds      <= 1'b0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 8'd1;
            door_s1 <= door_closed;
            ds      <= door_s1;
        end
    end

    // 9-bit sum so the ramp step can never wrap past MAX_DUTY.
    assign duty_sum = {1'b0, duty} + 9'(RAMP_STEP);

    always_comb begin
        state_n = state;
        dir_n   = dir;
        duty_n  = duty;
        timer_n = timer;
        rev_n   = reversals;
        if (!en) begin
            state_n = IDLE;
            dir_n   = FWD;
            duty_n  = 8'd0;
            timer_n = 16'd0;
        end else if (!ds) begin
            state_n = FAULT;
            duty_n  = 8'd0;
            timer_n = 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = RAMP;
                    dir_n   = FWD;
                    duty_n  = 8'd0;
                    timer_n = 16'd0;
                    rev_n   = 8'd0;
                end
                RAMP: begin
                    if (tick) begin
                        duty_n = (duty_sum >= 9'(MAX_DUTY)) ? 8'(MAX_DUTY) : duty_sum[7:0];
                        if (duty_n == 8'(MAX_DUTY)) begin
                            state_n = RUN;
                            timer_n = 16'd0;
                        end
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (timer == 16'(RUN_TICKS - 1)) begin
                            state_n = PAUSE;
                            duty_n  = 8'd0;
                            timer_n = 16'd0;
                        end else begin
                            timer_n = timer + 16'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (tick) begin
                        if (timer == 16'(PAUSE_TICKS - 1)) begin
                            state_n = RAMP;
                            dir_n   = (dir == FWD) ? REV : FWD;
                            duty_n  = 8'd0;
                            timer_n = 16'd0;
                            rev_n   = (reversals == 8'hFF) ? reversals : reversals + 8'd1;
                        end else begin
                            timer_n = timer + 16'd1;
                        end
                    end
                end
                FAULT: begin
                    duty_n = 8'd0;
                end
                default: begin
                    state_n = IDLE;
                    duty_n  = 8'd0;
                end
            endcase
        end
    end

    // The PWM register is gated by the next state. This lets an en drop or
    // a fault clear the gate on the same edge that leaves RAMP/RUN.
    assign drive_n = (state_n == RAMP) || (state_n == RUN);

    always_ff @(posedge clk or negedge O) begin
        if (!O) begin
            state     <= IDLE;
            dir       <= FWD;
            duty      <= 8'd0;
            timer     <= 16'd0;
            reversals <= 8'd0;
            pwm       <= 1'b0;
        end else begin
            state     <= state_n;
            dir       <= dir_n;
            duty      <= duty_n;
            timer     <= timer_n;
            reversals <= rev_n;
            pwm       <= drive_n && (pwm_cnt < duty_n);
        end
    end

    assign running   = (state == RAMP) || (state == RUN);
    assign fault     = (state == FAULT);
    assign dir_fwd   = running && (dir == FWD);
    assign dir_rev   = running && (dir == REV);
    assign state_dbg = state;

endmodule

// File: tb/tb_drum_motor_driver.sv
module tb_drum_motor_driver;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RAMP  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  logic clk = 1'b0;
  logic O = 1'b0;
  logic en = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic door_closed = 1'b1;

  logic pwm, dir_fwd, dir_rev, running, fault;
  logic [7:0] reversals;
  logic [2:0] state_dbg;
  logic pwm_b, dir_fwd_b, dir_rev_b, running_b, fault_b;
  logic [7:0] reversals_b;
  logic [2:0] state_dbg_b;
  logic pwm_c, dir_fwd_c, dir_rev_c, running_c, fault_c;
  logic [7:0] reversals_c;
  logic [2:0] state_dbg_c;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk or negedge O)
    if (!O) cyc <= 0;
    else cyc <= cyc + 1;

  drum_motor_driver #(.TICK_DIV(4), .RAMP_STEP(50), .MAX_DUTY(200), .RUN_TICKS(10), .PAUSE_TICKS(3)) u_dut (
    .clk(clk), .O(O), .en(en), .door_closed(door_closed),
    .pwm(pwm), .dir_fwd(dir_fwd), .dir_rev(dir_rev), .running(running),
    .fault(fault), .reversals(reversals), .state_dbg(state_dbg));

  drum_motor_driver #(.TICK_DIV(4), .RAMP_STEP(50), .MAX_DUTY(200), .RUN_TICKS(1), .PAUSE_TICKS(1)) u_sat (
    .clk(clk), .O(O), .en(en_b), .door_closed(door_closed),
    .pwm(pwm_b), .dir_fwd(dir_fwd_b), .dir_rev(dir_rev_b), .running(running_b),
    .fault(fault_b), .reversals(reversals_b), .state_dbg(state_dbg_b));

  drum_motor_driver #(.TICK_DIV(4), .RAMP_STEP(50), .MAX_DUTY(200), .RUN_TICKS(100), .PAUSE_TICKS(3)) u_long (
    .clk(clk), .O(O), .en(en_c), .door_closed(door_closed),
    .pwm(pwm_c), .dir_fwd(dir_fwd_c), .dir_rev(dir_rev_c), .running(running_c),
    .fault(fault_c), .reversals(reversals_c), .state_dbg(state_dbg_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns the cycle index of the edge that entered s.
  task automatic wait_state(input string tag, input logic [2:0] s, input int budget, output int at);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    chk(tag, 32'(state_dbg), 32'(s));
  endtask

  initial begin
    int n_ramp, n_run, n_pause, n_ramp2, n, errs, hi;
    logic [7:0] prev;
    logic wrapped;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_dir_fwd", 32'(dir_fwd), 0);
    chk("rst_dir_rev", 32'(dir_rev), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_reversals", 32'(reversals), 0);
    O = 1'b1;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({pwm, dir_fwd, dir_rev, running, fault} !== 5'b0 || reversals !== 8'd0) errs++;
    end
    chk("idle_quiet", 32'(errs), 0);

    // asynchronous reset while running
    en = 1'b1;
    wait_state("first_ramp", ST_RAMP, 10, n_ramp);
    wait_state("first_run", ST_RUN, 40, n_run);
    n = 0;
    while (pwm !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("pwm_seen_high", 32'(pwm), 1);
    O = 1'b0;
    en = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm), 0);
    chk("async_rst_dir_fwd", 32'(dir_fwd), 0);
    chk("async_rst_running", 32'(running), 0);
    @(negedge clk);
    O = 1'b1;
    repeat (5) @(negedge clk);

    // ramp, run, pause, reversal
    en = 1'b1;
    wait_state("ramp", ST_RAMP, 10, n_ramp);
    chk("ramp_running", 32'(running), 1);
    chk("ramp_dir_fwd", 32'(dir_fwd), 1);
    chk("ramp_dir_rev", 32'(dir_rev), 0);
    wait_state("run", ST_RUN, 40, n_run);
    chk("ramp_ticks", 32'(n_run / 4 - n_ramp / 4), 4);
    chk("run_on_tick", 32'(n_run % 4), 0);
    errs = 0;
    n = 0;
    while (state_dbg === ST_RUN && n < 100) begin
      if (pwm !== (((cyc - 1) % 256) < 200)) errs++;
      @(negedge clk);
      n++;
    end
    chk("run_pwm_pattern", 32'(errs), 0);
    wait_state("pause", ST_PAUSE, 5, n_pause);
    chk("run_len", 32'(n_pause - n_run), 40);
    errs = 0;
    n = 0;
    while (state_dbg === ST_PAUSE && n < 50) begin
      if ({pwm, dir_fwd, dir_rev, running} !== 4'b0) errs++;
      @(negedge clk);
      n++;
    end
    chk("pause_quiet", 32'(errs), 0);
    wait_state("ramp_rev", ST_RAMP, 5, n_ramp2);
    chk("pause_len", 32'(n_ramp2 - n_pause), 12);
    chk("rev1_dir_rev", 32'(dir_rev), 1);
    chk("rev1_dir_fwd", 32'(dir_fwd), 0);
    chk("rev1_count", 32'(reversals), 1);
    @(negedge clk);
    wait_state("pause2", ST_PAUSE, 200, n_pause);
    wait_state("ramp_fwd", ST_RAMP, 50, n_ramp2);
    chk("rev2_dir_fwd", 32'(dir_fwd), 1);
    chk("rev2_dir_rev", 32'(dir_rev), 0);
    chk("rev2_count", 32'(reversals), 2);

    // door opens during RUN
    wait_state("run_for_door", ST_RUN, 40, n_run);
    door_closed = 1'b0;
    repeat (3) @(negedge clk);
    chk("door_fault", 32'(fault), 1);
    chk("door_pwm", 32'(pwm), 0);
    chk("door_running", 32'(running), 0);
    chk("door_dir_fwd", 32'(dir_fwd), 0);
    door_closed = 1'b1;
    repeat (20) @(negedge clk);
    chk("fault_latched", 32'(state_dbg), 32'(ST_FAULT));
    chk("fault_rev_held", 32'(reversals), 2);
    en = 1'b0;
    @(negedge clk);
    chk("fault_clear", 32'(fault), 0);
    chk("fault_to_idle", 32'(state_dbg), 32'(ST_IDLE));
    en = 1'b1;
    @(negedge clk);
    chk("restart_running", 32'(running), 1);
    chk("restart_dir_fwd", 32'(dir_fwd), 1);
    chk("restart_rev_clr", 32'(reversals), 0);

    // en drop during PAUSE after one reversal
    wait_state("p_a", ST_PAUSE, 200, n_pause);
    wait_state("r_a", ST_RAMP, 50, n_ramp2);
    @(negedge clk);
    wait_state("p_b", ST_PAUSE, 200, n_pause);
    en = 1'b0;
    @(negedge clk);
    chk("endrop_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("endrop_rev_held", 32'(reversals), 1);
    chk("endrop_dirs", 32'({dir_fwd, dir_rev}), 0);
    en = 1'b1;
    @(negedge clk);
    chk("reen_rev_clr", 32'(reversals), 0);
    chk("reen_dir_fwd", 32'(dir_fwd), 1);
    chk("reen_dir_rev", 32'(dir_rev), 0);
    en = 1'b0;

    // full-duty count over one carrier period
    en_c = 1'b1;
    n = 0;
    while (state_dbg_c !== ST_RUN && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("long_run", 32'(state_dbg_c), 32'(ST_RUN));
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (pwm_c === 1'b1) hi++;
      @(negedge clk);
    end
    chk("run_pwm_200_of_256", 32'(hi), 200);
    en_c = 1'b0;

    // reversal counter saturation
    en_b = 1'b1;
    prev = 8'd0;
    wrapped = 1'b0;
    for (int i = 0; i < 6500; i++) begin
      @(negedge clk);
      if (reversals_b < prev) wrapped = 1'b1;
      prev = reversals_b;
    end
    chk("sat_255", 32'(reversals_b), 255);
    chk("sat_no_wrap", 32'(wrapped), 0);
    en_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
